if_id_hazard_ctrl: RTL and testbench

- Pipeline hazard controller that sequences the IF/ID pipeline register and the PC.
- Generates pc_write, if_write (IF/ID write enable), if_id_flush and id_ex_flush from three inputs:
  - load-use dependency between ID and EX;
  - branch-misprediction resolution in EX;
  - data-memory busy.
- Holds a small recovery FSM for multi-cycle flushes and saturating event counters for stall and flush statistics.
- Sits beside the IF/ID and ID/EX registers in the core top.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/if_id_hazard_ctrl_if.sv | 38 +++
 rtl/sat_counter.sv | 22 ++
 rtl/if_id_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_if_id_hazard_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the IF/ID hazard controller.
//   state_t   : recovery FSM states (RUN, FLUSH)
//   REG_W_DEF : default register-address width
//   ZERO_REG  : architectural zero register; a load to it never creates a hazard
package hazard_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam int REG_W_DEF = 5;
    localparam int ZERO_REG  = 0;

endpackage

// File: rtl/if_id_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
//   master : datapath side, drives ID/EX hazard information, receives enables/flushes
//   slave  : controller side, receives hazard information, drives enables/flushes/counters
interface if_id_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_resolved;
    logic             ex_branch_taken;
    logic             ex_prediction;
    logic             dmem_busy;
    logic             pc_write;
    logic             if_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               ex_branch_resolved, ex_branch_taken, ex_prediction, dmem_busy,
        input  pc_write, if_write, if_id_flush, id_ex_flush,
               stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               ex_branch_resolved, ex_branch_taken, ex_prediction, dmem_busy,
        output pc_write, if_write, if_id_flush, id_ex_flush,
               stall_count, flush_count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for event statistics; sticks at all-ones.
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   inc        : count one event this cycle
//   count      : current value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID hazard controller: PC / IF/ID enables and IF/ID, ID/EX flushes from
// load-use, branch mispredict and data-memory busy, plus stall/flush statistics.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of if_id_hazard_ctrl_if (hazard inputs, control outputs, counters)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal flow; resolves freeze, mispredict and load-use
// ST_FLUSH | extra cycles of IF/ID flush after a mispredict; cnt = cycles left
module if_id_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32,
    parameter int REG_W        = REG_W_DEF
) (
    input logic              clk,
    input logic              rst_n,
    if_id_hazard_ctrl_if.slave bus
);

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use, mispredict;
    logic       stall_inc, flush_inc;
    logic       pc_write, if_write, if_id_flush, id_ex_flush;

    assign load_use = bus.ex_mem_read
                   && (bus.ex_rd != REG_W'(ZERO_REG))
                   && ((bus.ex_rd == bus.id_rs1)
                       || (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

    assign mispredict = bus.ex_branch_resolved
                     && (bus.ex_branch_taken != bus.ex_prediction);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        if_write    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (!rst_n) begin
            // Keep the pipe quiet and bubbled while reset is asserted.
            pc_write    = 1'b0;
            if_write    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (bus.dmem_busy) begin
            // Full freeze: EX re-presents its branch/load after release.
            pc_write    = 1'b0;
            if_write    = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mispredict) begin
                        if_write    = 1'b0;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            cnt_d   = CNT_INIT;
                        end
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_write    = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if_write    = 1'b0;
                    if_id_flush = 1'b1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.if_write    = if_write;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (bus.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (bus.flush_count)
    );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Bench for if_id_hazard_ctrl: two instances (FLUSH_CYCLES=1/CNT_W=32 and
// FLUSH_CYCLES=3/CNT_W=4) driven by the same stimulus, checked against a
// cycle-level reference that tracks "flush cycles still owed" and event totals.
module tb_if_id_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs2, ex_mem_read;
    logic       ex_branch_resolved, ex_branch_taken, ex_prediction, dmem_busy;

    always #5 clk = ~clk;

    if_id_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) hz1 ();
    if_id_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  hz3 ();

    assign hz1.id_rs1 = id_rs1;               assign hz3.id_rs1 = id_rs1;
    assign hz1.id_rs2 = id_rs2;               assign hz3.id_rs2 = id_rs2;
    assign hz1.id_uses_rs2 = id_uses_rs2;     assign hz3.id_uses_rs2 = id_uses_rs2;
    assign hz1.ex_mem_read = ex_mem_read;     assign hz3.ex_mem_read = ex_mem_read;
    assign hz1.ex_rd = ex_rd;                 assign hz3.ex_rd = ex_rd;
    assign hz1.ex_branch_resolved = ex_branch_resolved;
    assign hz3.ex_branch_resolved = ex_branch_resolved;
    assign hz1.ex_branch_taken = ex_branch_taken;
    assign hz3.ex_branch_taken = ex_branch_taken;
    assign hz1.ex_prediction = ex_prediction; assign hz3.ex_prediction = ex_prediction;
    assign hz1.dmem_busy = dmem_busy;         assign hz3.dmem_busy = dmem_busy;

    if_id_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32), .REG_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(hz1.slave));
    if_id_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4), .REG_W(5)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(hz3.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: index 0 -> dut1, index 1 -> dut3
    int              fc[2]      = '{1, 3};
    longint unsigned cmax[2]    = '{64'hFFFF_FFFF, 64'd15};
    int              owed[2];
    longint unsigned stall_m[2];
    longint unsigned flush_m[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit lu_now();
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    endfunction

    function automatic bit mis_now();
        return ex_branch_resolved && (ex_branch_taken != ex_prediction);
    endfunction

    // {pc_write, if_write, if_id_flush, id_ex_flush}
    function automatic logic [3:0] exp_ctrl(input int k);
        if (dmem_busy)    return 4'b0000;
        if (owed[k] > 0)  return 4'b1010;
        if (mis_now())    return 4'b1011;
        if (lu_now())     return 4'b0001;
        return 4'b1100;
    endfunction

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            if (!dmem_busy) begin
                if (owed[k] > 0) begin
                    owed[k]--;
                end else if (mis_now()) begin
                    if (flush_m[k] < cmax[k]) flush_m[k]++;
                    owed[k] = fc[k] - 1;
                end else if (lu_now()) begin
                    if (stall_m[k] < cmax[k]) stall_m[k]++;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owed[k] = 0; stall_m[k] = 0; flush_m[k] = 0;
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                         input logic mr, input logic [4:0] rd, input logic br,
                         input logic tk, input logic pr, input logic busy);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; ex_mem_read = mr; ex_rd = rd;
        ex_branch_resolved = br; ex_branch_taken = tk; ex_prediction = pr; dmem_busy = busy;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called just after a rising edge with inputs applied.
    task automatic step();
        logic [3:0] e1, e3;
        #4;
        e1 = exp_ctrl(0);
        e3 = exp_ctrl(1);
        check("ctrl_fc1", {28'd0, hz1.pc_write, hz1.if_write, hz1.if_id_flush, hz1.id_ex_flush}, {28'd0, e1});
        check("ctrl_fc3", {28'd0, hz3.pc_write, hz3.if_write, hz3.if_id_flush, hz3.id_ex_flush}, {28'd0, e3});
        @(posedge clk);
        model_clock();
        #1;
        check("stall_fc1", hz1.stall_count, stall_m[0][31:0]);
        check("flush_fc1", hz1.flush_count, flush_m[0][31:0]);
        check("stall_fc3", {28'd0, hz3.stall_count}, stall_m[1][31:0]);
        check("flush_fc3", {28'd0, hz3.flush_count}, flush_m[1][31:0]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check("rst_ctrl_fc1", {28'd0, hz1.pc_write, hz1.if_write, hz1.if_id_flush, hz1.id_ex_flush}, 32'h3);
        check("rst_ctrl_fc3", {28'd0, hz3.pc_write, hz3.if_write, hz3.if_id_flush, hz3.id_ex_flush}, 32'h3);
        check("rst_stall_fc3", {28'd0, hz3.stall_count}, 32'd0);
        check("rst_flush_fc3", {28'd0, hz3.flush_count}, 32'd0);
        check("rst_stall_fc1", hz1.stall_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        idle();
        #2;
        check("por_ctrl_fc1", {28'd0, hz1.pc_write, hz1.if_write, hz1.if_id_flush, hz1.id_ex_flush}, 32'h3);
        check("por_ctrl_fc3", {28'd0, hz3.pc_write, hz3.if_write, hz3.if_id_flush, hz3.id_ex_flush}, 32'h3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Load-use, then the same with rd = x0
        drive(5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("lu_stall_cnt", hz1.stall_count, 32'd1);
        drive(5'd0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("x0_no_stall", hz1.stall_count, 32'd1);
        // rs2 match only counts when rs2 is used
        drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Mispredict, load-use in recovery cycle 2, then idle
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("mis_flush_cnt", hz1.flush_count, 32'd1);
        drive(5'd4, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle(); step(); step();

        // Freeze with mispredict and load-use present
        drive(5'd4, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        step();

        // Freeze for 4 cycles while two flush cycles are still owed
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end
        idle(); step(); step(); step();

        // Simultaneous mispredict and load-use
        drive(5'd6, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        idle(); step(); step(); step();

        // 20 back-to-back load-use stalls saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(5'd8, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        check("sat_stall_fc3", {28'd0, hz3.stall_count}, 32'd15);

        // Reset while the FLUSH_CYCLES=3 instance is recovering
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        do_reset();
        step();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 6) == 0));
            if ($urandom_range(0, 399) == 0) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
